// File: rtl/gat_pkg.sv
// rtl/gat_pkg.sv - shared FSM encoding and byte-address constant for the GAT blocks
package gat_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} gat_state_e;
  localparam int BYTE_ADDR_SHIFT = 2;
endpackage

// File: rtl/gat_sync_fifo.sv
// rtl/gat_sync_fifo.sv - synchronous FIFO with occupancy count; simultaneous push/pop allowed when full
module gat_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head is leaving in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/gat_feat_streamer.sv
// rtl/gat_feat_streamer.sv - streams one layer of output features from BRAM onto an AXI-Stream master
module gat_feat_streamer import gat_pkg::*; #(
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NEW_FEATURE_DEPTH = 43328,
  parameter int RD_LATENCY        = 2,
  parameter int FIFO_DEPTH        = 4,
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic                            stream_done,
  output logic                            busy
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);

  gat_state_e                    state;
  logic                          gat_ready_q;
  logic [NEW_FEATURE_ADDR_W-1:0] rd_idx, beat_cnt;
  logic [RD_LATENCY-1:0]         rd_pipe;
  logic [CNT_W-1:0]              outstanding, fifo_count;
  logic [CNT_W:0]                occupancy;
  logic [NEW_FEATURE_WIDTH-1:0]  fifo_head;
  logic                          start, issue, emerge, pop, fifo_empty;

  assign start    = gat_ready && !gat_ready_q;
  assign emerge   = rd_pipe[RD_LATENCY-1];
  assign m_tvalid = !fifo_empty;
  assign pop      = m_tvalid && m_tready;
  // Credit counts words in flight plus words held, net of the word leaving this cycle,
  // so a FIFO of RD_LATENCY+1 entries sustains one word per cycle.
  assign occupancy = (CNT_W+1)'(outstanding) + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop);
  assign issue     = (state == ST_READ) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

  assign feat_bram_addrb = {rd_idx, {BYTE_ADDR_SHIFT{1'b0}}};
  assign m_tdata         = m_tvalid ? fifo_head : '0;
  assign m_tlast         = m_tvalid && (beat_cnt == LAST_IDX);
  assign stream_done     = (state == ST_DONE);
  assign busy            = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gat_ready_q <= 1'b0;
      rd_idx      <= '0;
      beat_cnt    <= '0;
      rd_pipe     <= '0;
      outstanding <= '0;
    end else begin
      gat_ready_q <= gat_ready;
      rd_pipe     <= (rd_pipe << 1) | RD_LATENCY'(issue);
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(emerge);
      if (pop) beat_cnt <= beat_cnt + NEW_FEATURE_ADDR_W'(1);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_READ;
            rd_idx   <= '0;
            beat_cnt <= '0;
          end
        end
        ST_READ: begin
          if (issue) begin
            if (rd_idx == LAST_IDX) state <= ST_DRAIN;
            else                    rd_idx <= rd_idx + NEW_FEATURE_ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (pop && m_tlast) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  gat_sync_fifo #(
    .WIDTH(NEW_FEATURE_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (emerge),
    .push_data(feat_bram_dout),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );
endmodule

// File: tb/tb_gat_feat_streamer.sv
// tb/tb_gat_feat_streamer.sv - scoreboard bench for gat_feat_streamer against a BRAM model
module tb_gat_feat_streamer;
  parameter int W      = 32;
  parameter int DEPTH  = 16;
  parameter int LAT    = 3;
  parameter int FDEPTH = 4;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n, gat_ready, m_tready;
  logic [ADDR_W+1:0] feat_bram_addrb;
  logic [W-1:0]      feat_bram_dout, m_tdata;
  logic              m_tvalid, m_tlast, stream_done, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  int beats, lasts, first_cyc, last_cyc, done_cyc;
  logic [W-1:0] exp_data[$];
  logic         exp_last[$];
  logic [W-1:0] bram [DEPTH];
  logic [W-1:0] rd_stage [LAT];

  gat_feat_streamer #(
    .NEW_FEATURE_WIDTH(W),
    .NEW_FEATURE_DEPTH(DEPTH),
    .RD_LATENCY(LAT),
    .FIFO_DEPTH(FDEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gat_ready(gat_ready),
    .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .stream_done(stream_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM with LAT cycles from address to data
  always @(posedge clk) begin
    rd_stage[0] <= bram[feat_bram_addrb[ADDR_W+1:2]];
    for (int i = 1; i < LAT; i++) rd_stage[i] <= rd_stage[i-1];
  end
  assign feat_bram_dout = rd_stage[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a stream delivers every BRAM word in address order, last flag only on the final word.
  task automatic load_stream();
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < DEPTH; i++) begin
      bram[i] = $urandom;
      exp_data.push_back(bram[i]);
      exp_last.push_back(i == DEPTH - 1);
    end
    beats = 0; lasts = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!stream_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", 64'(stream_done), 64'd1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (beats < target && n < budget) begin
      tick();
      n++;
    end
    check("beats_reached", 64'(beats >= target), 64'd1);
  endtask

  task automatic check_stream_end(input string tag);
    check({tag, "_beats"}, 64'(beats), 64'(DEPTH));
    check({tag, "_tlast_count"}, 64'(lasts), 64'd1);
    check({tag, "_scoreboard_empty"}, 64'(exp_data.size()), 64'd0);
    check({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_cyc + 1));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: m_tready = 1'b1;
        1: m_tready = ($urandom_range(0, 99) < 30);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted beat
  initial begin
    logic         held;
    logic [W-1:0] held_data;
    held = 1'b0;
    held_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) check("tdata_stable", {m_tvalid, m_tdata}, {1'b1, held_data});
        if (busy)
          check("credit_bound", 64'(int'(dut.outstanding) + int'(dut.fifo_count) <= FDEPTH), 64'd1);
        if (m_tvalid && m_tready) begin
          if (exp_data.size() == 0) begin
            check("unexpected_beat", 64'(beats), 64'(DEPTH));
          end else begin
            check("beat_data", 64'(m_tdata), 64'(exp_data.pop_front()));
            check("beat_last", 64'(m_tlast), 64'(exp_last.pop_front()));
          end
          beats++;
          if (beats == 1) first_cyc = cyc;
          if (m_tlast) begin
            lasts++;
            last_cyc = cyc;
          end
        end
        if (stream_done) done_cyc = cyc;
        held = m_tvalid && !m_tready;
        held_data = m_tdata;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    gat_ready = 1'b0;
    m_tready = 1'b1;
    load_stream();
    repeat (3) tick();
    check("rst_addrb", 64'(feat_bram_addrb), 64'd0);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_done", 64'(stream_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Back-pressure-free stream: latency, one word per cycle, done pulse
    mode = 0;
    load_stream();
    gat_ready = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    while (!m_tvalid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("first_valid_latency", 64'(n), 64'(LAT + 1));
    wait_done(200);
    check_stream_end("s1");
    check("s1_consecutive", 64'(last_cyc - first_cyc), 64'(DEPTH - 1));
    tick();
    check("done_one_cycle", 64'(stream_done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
    repeat (5) tick();
    check("held_high_no_retrigger", 64'(busy), 64'd0);

    // Ten-cycle stall mid-stream
    gat_ready = 1'b0;
    tick();
    load_stream();
    gat_ready = 1'b1;
    wait_beats(5, 100);
    mode = 2;
    repeat (10) tick();
    mode = 0;
    wait_done(200);
    check_stream_end("s2");

    // Random back-pressure with gat_ready toggled while reading
    gat_ready = 1'b0;
    tick();
    load_stream();
    gat_ready = 1'b1;
    mode = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      gat_ready = ~gat_ready;
    end
    wait_done(4000);
    check_stream_end("s3");
    mode = 0;
    gat_ready = 1'b0;
    repeat (3) tick();

    // Reset after beat 3; gat_ready left high restarts from word 0 once reset releases
    load_stream();
    gat_ready = 1'b1;
    wait_beats(3, 100);
    rst_n = 1'b0;
    #1;
    check("midrst_addrb", 64'(feat_bram_addrb), 64'd0);
    check("midrst_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_tlast", 64'(m_tlast), 64'd0);
    check("midrst_tdata", 64'(m_tdata), 64'd0);
    check("midrst_done", 64'(stream_done), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    tick();
    load_stream();
    rst_n = 1'b1;
    wait_done(200);
    check_stream_end("s4");
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
